// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Iterative multiply/divide sequencer that owns the architectural HI/LO
//   register pair. One result bit is produced per clock: shift-add for
//   mult/multu and restoring division for div/divu. The execute stage
//   issues operations through a start/busy/done handshake. mthi/mtlo writes
//   and pipeline flushes are also handled here.
//
// Ports
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_start   issue an operation (only honoured in IDLE)
//   i_op      0 = mult, 1 = multu, 2 = divu, 3 = div
//   i_a       multiplicand / dividend
//   i_b       multiplier / divisor
//   i_flush   abort an in-flight operation (or drop a start issued in IDLE)
//   i_wr_hi   mthi write strobe
//   i_wr_lo   mtlo write strobe
//   i_wdata   mthi/mtlo data
//   o_busy    operation in flight (CALC or FIX)
//   o_done    one-cycle pulse in the cycle after HI/LO are written
//   o_dz      last completed division had a zero divisor
//   o_hi      HI register
//   o_lo      LO register

module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  input  logic             i_wr_hi,
  input  logic             i_wr_lo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Sequencing strobes decoded from the current state
  logic w_load;
  logic w_iter;
  logic w_commit;
  logic w_mtAllowed;

  // Latched operation context
  logic [CW-1:0]      r_count;
  logic               r_isDiv;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_resNeg;
  logic               r_remNeg;
  logic [WIDTH-1:0]   r_aOrig;
  logic               r_divZero;

  // Architectural results
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dz;

  // Operand preparation
  logic               w_isDiv;
  logic               w_isSigned;
  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;

  // Iteration datapath
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_divShift;
  logic [WIDTH:0]     w_divDiff;
  logic [2*WIDTH-1:0] w_divNext;

  // Sign correction
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

  // Operands are held as magnitudes while iterating. Only mult (0) and
  // div (3) are signed, so the sign flags stay clear for the unsigned ops.
  assign w_isDiv    = i_op[1];
  assign w_isSigned = (i_op == 2'd0) || (i_op == 2'd3);
  assign w_aNeg     = w_isSigned & i_a[WIDTH-1];
  assign w_bNeg     = w_isSigned & i_b[WIDTH-1];
  assign w_aMag     = w_aNeg ? -i_a : i_a;
  assign w_bMag     = w_bNeg ? -i_b : i_b;

  // Multiply step. The upper half of the accumulator collects partial sums
  // and the lower half holds the multiplier, which is consumed LSB first.
  // The carry out of the add is shifted back into the top bit.
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mulNext = r_acc[0] ? {w_mulSum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring divide step. The upper half is the partial remainder and the
  // lower half shifts the dividend out MSB first while quotient bits shift
  // in. A set top bit on the difference means it borrowed, so the
  // remainder is restored.
  assign w_divShift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_divDiff  = w_divShift - {1'b0, r_opnd};
  assign w_divNext  = w_divDiff[WIDTH]
                      ? {w_divShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_divDiff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  // Final sign correction. The remainder follows the dividend's sign.
  assign w_prodFix = r_resNeg ? -r_acc : r_acc;
  assign w_quotFix = r_resNeg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remFix  = r_remNeg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // State register. Reset aborts any operation immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and strobe decode. A flush in CALC or FIX returns to IDLE
  // without committing. A flush in IDLE drops a coincident start. A start
  // outside IDLE is simply not looked at. mthi/mtlo are honoured only when
  // no operation is in flight.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    w_commit    = 1'b0;
    w_mtAllowed = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mtAllowed = 1'b1;
        if (i_start && !i_flush) begin
          w_load      = 1'b1;
          w_nextState = S_CALC;
        end
      end
      S_CALC: begin
        o_busy = 1'b1;
        if (i_flush) begin
          w_nextState = S_IDLE;
        end else begin
          w_iter = 1'b1;
          if (r_count == CW'(1)) begin
            w_nextState = S_FIX;
          end
        end
      end
      S_FIX: begin
        o_busy = 1'b1;
        if (i_flush) begin
          w_nextState = S_IDLE;
        end else begin
          w_commit    = 1'b1;
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_mtAllowed = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Operation context and iteration. For multiply the accumulator starts
  // with the multiplier in its low half. For divide it starts with the
  // dividend there. The original a is kept for the divide-by-zero HI value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_resNeg  <= 1'b0;
      r_remNeg  <= 1'b0;
      r_aOrig   <= '0;
      r_divZero <= 1'b0;
    end else if (w_load) begin
      r_count   <= CW'(WIDTH);
      r_isDiv   <= w_isDiv;
      r_opnd    <= w_isDiv ? w_bMag : w_aMag;
      r_acc     <= {{WIDTH{1'b0}}, (w_isDiv ? w_aMag : w_bMag)};
      r_resNeg  <= w_aNeg ^ w_bNeg;
      r_remNeg  <= w_aNeg;
      r_aOrig   <= i_a;
      r_divZero <= (i_b == '0);
    end else if (w_iter) begin
      r_count <= r_count - CW'(1);
      r_acc   <= r_isDiv ? w_divNext : w_mulNext;
    end
  end

  // HI/LO/dz. A completing operation owns the registers. Otherwise mthi and
  // mtlo land here whenever the sequencer is not busy, including an IDLE
  // cycle that also issues a start. Any completion rewrites dz, so a
  // multiply clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
      r_dz <= 1'b0;
    end else if (w_commit) begin
      r_dz <= r_isDiv & r_divZero;
      if (r_isDiv && r_divZero) begin
        r_hi <= r_aOrig;
        r_lo <= '1;
      end else if (r_isDiv) begin
        r_hi <= w_remFix;
        r_lo <= w_quotFix;
      end else begin
        r_hi <= w_prodFix[2*WIDTH-1:WIDTH];
        r_lo <= w_prodFix[WIDTH-1:0];
      end
    end else if (w_mtAllowed) begin
      if (i_wr_hi) begin
        r_hi <= i_wdata;
      end
      if (i_wr_lo) begin
        r_lo <= i_wdata;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
  assign o_dz = r_dz;

endmodule
